// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode/funct constants, ALU control codes and the
// decoded-control bundle handed from alu_decode to the ID/EX controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LB    = 6'd32;
  localparam logic [5:0] OP_LH    = 6'd33;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SB    = 6'd40;
  localparam logic [5:0] OP_SH    = 6'd41;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_JR  = 6'd8;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_XOR = 6'd38;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [1:0] {
    EXT_SIGN = 2'd0,
    EXT_ZERO = 2'd1,
    EXT_LUI  = 2'd2
  } ext_mode_e;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       bne;
    logic       use_imm;   // B operand is the extended immediate
    logic       dest_rd;   // write-back register is rd rather than rt
    logic       uses_rt;   // rt is read as a source (hazard relevant)
    ext_mode_e  ext;
    logic       illegal;
    logic       jump;      // j/jal: valid slot with no EX work
  } dec_ctrl_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct decoder producing the EX control bundle.
module alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    ctrl.ext = EXT_SIGN;
    case (opcode)
      OP_RTYPE: begin
        ctrl.dest_rd = 1'b1;
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: begin
            ctrl.reg_write = 1'b1;
            ctrl.uses_rt   = 1'b1;
            case (funct)
              FN_ADD:  ctrl.alu_control = ALU_ADD;
              FN_SUB:  ctrl.alu_control = ALU_SUB;
              FN_AND:  ctrl.alu_control = ALU_AND;
              FN_OR:   ctrl.alu_control = ALU_OR;
              FN_XOR:  ctrl.alu_control = ALU_XOR;
              FN_NOR:  ctrl.alu_control = ALU_NOR;
              default: ctrl.alu_control = ALU_SLT;
            endcase
          end
          FN_JR:   ctrl.alu_control = ALU_ADD;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.use_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (opcode)
          OP_ADDI: ctrl.alu_control = ALU_ADD;
          OP_SLTI: ctrl.alu_control = ALU_SLT;
          OP_ANDI: begin ctrl.alu_control = ALU_AND; ctrl.ext = EXT_ZERO; end
          OP_ORI:  begin ctrl.alu_control = ALU_OR;  ctrl.ext = EXT_ZERO; end
          OP_XORI: begin ctrl.alu_control = ALU_XOR; ctrl.ext = EXT_ZERO; end
          default: begin ctrl.alu_control = ALU_ADD; ctrl.ext = EXT_LUI;  end
        endcase
      end
      OP_LB, OP_LH, OP_LW: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.use_imm     = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.use_imm     = 1'b1;
        ctrl.mem_write   = 1'b1;
        ctrl.uses_rt     = 1'b1;   // store data comes from rt
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_control = ALU_SUB;
        ctrl.branch      = 1'b1;
        ctrl.bne         = (opcode == OP_BNE);
        ctrl.uses_rt     = 1'b1;
      end
      OP_J, OP_JAL: ctrl.jump = 1'b1;
      default:      ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ID/EX controller: decode, ID/EX pipeline register, load-use stall, flush,
// and EX-stage operand forwarding from MEM/WB.
module alu_issue_ctrl
  import mips_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [5:0]       id_funct,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic [XLEN-1:0]  id_rs_data,
  input  logic [XLEN-1:0]  id_rt_data,
  input  logic [15:0]      id_imm,
  input  logic             flush,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic [RADDR-1:0] mem_dest,
  input  logic [RADDR-1:0] wb_dest,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [XLEN-1:0]  wb_result,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_control,
  output logic [XLEN-1:0]  ex_op_a,
  output logic [XLEN-1:0]  ex_op_b,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [RADDR-1:0] ex_dest,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_bne,
  output logic             ex_illegal
);

  dec_ctrl_t dc;

  alu_decode u_dec (
    .opcode (id_opcode),
    .funct  (id_funct),
    .ctrl   (dc)
  );

  logic [RADDR-1:0] id_dest;
  logic             id_reg_write;
  logic [XLEN-1:0]  id_imm_ext;
  logic             hazard;
  logic             load_id;

  assign id_dest      = dc.dest_rd ? id_rd : id_rt;
  assign id_reg_write = dc.reg_write && (id_dest != '0);

  always_comb begin
    id_imm_ext = {{(XLEN-16){id_imm[15]}}, id_imm};
    case (dc.ext)
      EXT_ZERO: id_imm_ext = {{(XLEN-16){1'b0}}, id_imm};
      EXT_LUI:  id_imm_ext = XLEN'({id_imm, 16'h0000});
      default:  id_imm_ext = {{(XLEN-16){id_imm[15]}}, id_imm};
    endcase
  end

  // ex_dest is zeroed for non-writing slots, so a load to r0 never stalls.
  assign hazard   = ex_valid && ex_mem_read && (ex_dest != '0) &&
                    ((ex_dest == id_rs) || ((ex_dest == id_rt) && dc.uses_rt));
  assign stall_id = id_valid && hazard && !flush;
  assign load_id  = id_valid && !flush && !stall_id;

  // Operand state kept for EX-stage forwarding.
  logic [RADDR-1:0] ex_rs, ex_rt;
  logic [XLEN-1:0]  ex_rs_data, ex_rt_data, ex_imm;
  logic             ex_use_imm, ex_a_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_alu_control <= '0;
      ex_dest        <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_bne         <= 1'b0;
      ex_illegal     <= 1'b0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_rs_data     <= '0;
      ex_rt_data     <= '0;
      ex_imm         <= '0;
      ex_use_imm     <= 1'b0;
      ex_a_zero      <= 1'b0;
    end else begin
      // Bubble by default; overridden below when an instruction is accepted.
      ex_valid       <= 1'b0;
      ex_alu_control <= '0;
      ex_dest        <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_bne         <= 1'b0;
      ex_illegal     <= 1'b0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_rs_data     <= '0;
      ex_rt_data     <= '0;
      ex_imm         <= '0;
      ex_use_imm     <= 1'b0;
      ex_a_zero      <= 1'b0;
      if (load_id) begin
        if (dc.illegal) begin
          ex_illegal <= 1'b1;
        end else if (dc.jump) begin
          ex_valid <= 1'b1;
        end else begin
          ex_valid       <= 1'b1;
          ex_alu_control <= dc.alu_control;
          ex_reg_write   <= id_reg_write;
          ex_dest        <= id_reg_write ? id_dest : '0;
          ex_mem_read    <= dc.mem_read;
          ex_mem_write   <= dc.mem_write;
          ex_branch      <= dc.branch;
          ex_bne         <= dc.bne;
          ex_rs          <= id_rs;
          ex_rt          <= id_rt;
          ex_rs_data     <= id_rs_data;
          ex_rt_data     <= id_rt_data;
          ex_imm         <= id_imm_ext;
          ex_use_imm     <= dc.use_imm;
          ex_a_zero      <= (dc.ext == EXT_LUI) && dc.use_imm;
        end
      end
    end
  end

  // MEM beats WB; r0 and non-writing stages never forward.
  logic [XLEN-1:0] fwd_rs, fwd_rt;

  always_comb begin
    fwd_rs = ex_rs_data;
    if (ex_rs != '0 && mem_reg_write && mem_dest == ex_rs)
      fwd_rs = mem_result;
    else if (ex_rs != '0 && wb_reg_write && wb_dest == ex_rs)
      fwd_rs = wb_result;
  end

  always_comb begin
    fwd_rt = ex_rt_data;
    if (ex_rt != '0 && mem_reg_write && mem_dest == ex_rt)
      fwd_rt = mem_result;
    else if (ex_rt != '0 && wb_reg_write && wb_dest == ex_rt)
      fwd_rt = wb_result;
  end

  assign ex_op_a       = ex_a_zero  ? '0     : fwd_rs;
  assign ex_op_b       = ex_use_imm ? ex_imm : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: table vectors, hand sequences for stall/flush/
// forwarding/reset, then random traffic against a behavioural model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_dest, wb_dest;
  logic [31:0] mem_result, wb_result;
  logic        stall_id, ex_valid;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_op_a, ex_op_b, ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_bne, ex_illegal;

  alu_issue_ctrl #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .flush(flush), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_dest(mem_dest), .wb_dest(wb_dest), .mem_result(mem_result),
    .wb_result(wb_result), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_alu_control(ex_alu_control), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_bne(ex_bne), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] op; logic [5:0] fn;
    logic [4:0] rs; logic [4:0] rt; logic [4:0] rd;
    logic [31:0] rsd; logic [31:0] rtd; logic [15:0] imm;
  } ins_t;

  typedef struct packed {
    logic mrw; logic [4:0] md; logic [31:0] mres;
    logic wrw; logic [4:0] wd; logic [31:0] wres;
  } fwd_t;

  typedef struct packed {
    logic valid; logic [3:0] alu; logic [31:0] a; logic [31:0] b; logic [31:0] sd;
    logic [4:0] dest; logic rw, mr, mw, br, bne, ill;
  } out_t;

  typedef struct packed {
    bit legal, jump; bit [3:0] alu; bit rw, mr, mw, br, bne, immb, rd_dest, uses_rt;
    bit [1:0] ext;   // 0 sign, 1 zero, 2 upper
  } info_t;

  typedef struct {
    string nm; ins_t i; logic [3:0] exp_alu; logic [31:0] exp_b;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  logic [4:0] prev_ld;   // register a load in EX will write, 0 if none

  function automatic info_t dec(input logic [5:0] op, input logic [5:0] fn);
    info_t d = '0;
    d.legal = 1;
    case (op)
      0: begin
        d.rd_dest = 1; d.rw = 1; d.uses_rt = 1;
        case (fn)
          32: d.alu = 4'd2;  34: d.alu = 4'd6;  36: d.alu = 4'd0;
          37: d.alu = 4'd1;  38: d.alu = 4'd13; 39: d.alu = 4'd12;
          42: d.alu = 4'd7;
          8:  begin d.alu = 4'd2; d.rw = 0; d.uses_rt = 0; end
          default: begin d.legal = 0; d.rw = 0; d.uses_rt = 0; end
        endcase
      end
      2, 3: d.jump = 1;
      4, 5: begin d.alu = 4'd6; d.br = 1; d.bne = (op == 5); d.uses_rt = 1; end
      8:  begin d.alu = 4'd2;  d.immb = 1; d.rw = 1; end
      10: begin d.alu = 4'd7;  d.immb = 1; d.rw = 1; end
      12: begin d.alu = 4'd0;  d.immb = 1; d.rw = 1; d.ext = 1; end
      13: begin d.alu = 4'd1;  d.immb = 1; d.rw = 1; d.ext = 1; end
      14: begin d.alu = 4'd13; d.immb = 1; d.rw = 1; d.ext = 1; end
      15: begin d.alu = 4'd2;  d.immb = 1; d.rw = 1; d.ext = 2; end
      32, 33, 35: begin d.alu = 4'd2; d.immb = 1; d.mr = 1; d.rw = 1; end
      40, 41, 43: begin d.alu = 4'd2; d.immb = 1; d.mw = 1; d.uses_rt = 1; end
      default: d.legal = 0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] fwdv(input logic [4:0] src, input logic [31:0] rf, input fwd_t f);
    if (src != 0 && f.mrw && f.md == src) return f.mres;
    if (src != 0 && f.wrw && f.wd == src) return f.wres;
    return rf;
  endfunction

  function automatic out_t model(input bit acc, input ins_t i, input fwd_t f);
    out_t o = '0;
    info_t d = dec(i.op, i.fn);
    logic [31:0] immv;
    logic [4:0] dst;
    if (!acc) return o;
    if (!d.legal) begin o.ill = 1; return o; end
    o.valid = 1;
    if (d.jump) return o;
    case (d.ext)
      2'd0:    immv = 32'($signed(i.imm));
      2'd1:    immv = 32'(i.imm);
      default: immv = 32'(i.imm) * 32'd65536;
    endcase
    o.alu = d.alu;
    o.a   = (d.ext == 2 && d.immb) ? 32'd0 : fwdv(i.rs, i.rsd, f);
    o.sd  = fwdv(i.rt, i.rtd, f);
    o.b   = d.immb ? immv : o.sd;
    dst   = d.rd_dest ? i.rd : i.rt;
    o.rw  = d.rw && dst != 0;
    o.dest = o.rw ? dst : 5'd0;
    o.mr = d.mr; o.mw = d.mw; o.br = d.br; o.bne = d.bne;
    return o;
  endfunction

  function automatic ins_t mk(input logic [5:0] op, fn, input logic [4:0] rs, rt, rd,
                              input logic [31:0] rsd, rtd, input logic [15:0] imm);
    ins_t i;
    i.op = op; i.fn = fn; i.rs = rs; i.rt = rt; i.rd = rd;
    i.rsd = rsd; i.rtd = rtd; i.imm = imm;
    return i;
  endfunction

  function automatic vec_t mkv(input string nm, input ins_t i, input logic [3:0] a, input logic [31:0] b);
    vec_t v;
    v.nm = nm; v.i = i; v.exp_alu = a; v.exp_b = b;
    return v;
  endfunction

  function automatic out_t actual();
    out_t o;
    o.valid = ex_valid; o.alu = ex_alu_control; o.a = ex_op_a; o.b = ex_op_b;
    o.sd = ex_store_data; o.dest = ex_dest; o.rw = ex_reg_write; o.mr = ex_mem_read;
    o.mw = ex_mem_write; o.br = ex_branch; o.bne = ex_bne; o.ill = ex_illegal;
    return o;
  endfunction

  task automatic check_val(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic apply(input ins_t i, input bit v, input bit fl, input fwd_t f);
    id_valid = v; flush = fl;
    id_opcode = i.op; id_funct = i.fn; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_rs_data = i.rsd; id_rt_data = i.rtd; id_imm = i.imm;
    mem_reg_write = f.mrw; mem_dest = f.md; mem_result = f.mres;
    wb_reg_write = f.wrw; wb_dest = f.wd; wb_result = f.wres;
  endtask

  // One issue slot: drive ID, check stall, clock, check the EX register.
  task automatic do_cycle(input string nm, input ins_t i, input bit v, input bit fl, input fwd_t f);
    info_t d = dec(i.op, i.fn);
    bit exp_stall, acc;
    exp_stall = v && !fl && prev_ld != 0 &&
                (prev_ld == i.rs || (prev_ld == i.rt && d.uses_rt));
    acc = v && !fl && !exp_stall;
    apply(i, v, fl, f);
    #1;
    check_val({nm, " stall"}, 128'(stall_id), 128'(exp_stall));
    @(posedge clk); #1;
    check_val({nm, " ex"}, 128'(actual()), 128'(model(acc, i, f)));
    prev_ld = (acc && d.legal && d.mr && (i.rt != 0)) ? i.rt : 5'd0;
  endtask

  task automatic reset_cycle(input string nm, input ins_t i);
    rst = 1'b1;
    apply(i, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    check_val(nm, 128'(actual()), 128'(model(1'b0, i, '0)));
    check_val({nm, " stall"}, 128'(stall_id), 128'(0));
    prev_ld = 0;
    rst = 1'b0;
  endtask

  vec_t tbl[$];
  fwd_t nf;
  ins_t lw5, add5;

  initial begin
    nf = '0;
    prev_ld = 0;
    rst = 1'b1;
    apply('0, 1'b0, 1'b0, '0);
    reset_cycle("reset0", mk(35, 0, 1, 5, 0, 1, 2, 4));
    reset_cycle("reset1", mk(0, 32, 1, 2, 3, 5, 7, 0));

    tbl.push_back(mkv("add",   mk(0, 32, 1, 2, 3, 5, 7, 0),         4'b0010, 32'd7));
    tbl.push_back(mkv("sub",   mk(0, 34, 1, 2, 3, 9, 4, 0),         4'b0110, 32'd4));
    tbl.push_back(mkv("and",   mk(0, 36, 1, 2, 3, 32'hF0, 32'h3C, 0), 4'b0000, 32'h3C));
    tbl.push_back(mkv("or",    mk(0, 37, 1, 2, 4, 1, 2, 0),         4'b0001, 32'd2));
    tbl.push_back(mkv("xor",   mk(0, 38, 1, 2, 4, 1, 3, 0),         4'b1101, 32'd3));
    tbl.push_back(mkv("nor",   mk(0, 39, 1, 2, 4, 1, 8, 0),         4'b1100, 32'd8));
    tbl.push_back(mkv("slt",   mk(0, 42, 1, 2, 4, 1, 9, 0),         4'b0111, 32'd9));
    tbl.push_back(mkv("jr",    mk(0, 8, 1, 2, 0, 32'h400, 6, 0),    4'b0010, 32'd6));
    tbl.push_back(mkv("ori",   mk(13, 0, 1, 3, 0, 5, 0, 16'hFFFF),  4'b0001, 32'h0000FFFF));
    tbl.push_back(mkv("addi",  mk(8, 0, 1, 3, 0, 5, 0, 16'hFFFF),   4'b0010, 32'hFFFFFFFF));
    tbl.push_back(mkv("lui",   mk(15, 0, 1, 3, 0, 5, 0, 16'h1234),  4'b0010, 32'h12340000));
    tbl.push_back(mkv("slti",  mk(10, 0, 1, 3, 0, 5, 0, 16'h8000),  4'b0111, 32'hFFFF8000));
    tbl.push_back(mkv("andi",  mk(12, 0, 1, 3, 0, 5, 0, 16'h8001),  4'b0000, 32'h00008001));
    tbl.push_back(mkv("xori",  mk(14, 0, 1, 3, 0, 5, 0, 16'h00F0),  4'b1101, 32'h000000F0));
    tbl.push_back(mkv("lw",    mk(35, 0, 1, 6, 0, 5, 0, 16'h0004),  4'b0010, 32'd4));
    tbl.push_back(mkv("sw",    mk(43, 0, 1, 7, 0, 5, 32'hAB, 16'hFFFC), 4'b0010, 32'hFFFFFFFC));
    tbl.push_back(mkv("beq",   mk(4, 0, 1, 2, 0, 5, 7, 16'h0010),   4'b0110, 32'd7));
    tbl.push_back(mkv("bne",   mk(5, 0, 1, 2, 0, 5, 7, 16'h0010),   4'b0110, 32'd7));
    tbl.push_back(mkv("j",     mk(2, 0, 1, 2, 3, 5, 7, 16'h1111),   4'b0000, 32'd0));
    tbl.push_back(mkv("ill13", mk(0, 13, 1, 2, 3, 5, 7, 0),         4'b0000, 32'd0));
    tbl.push_back(mkv("illop", mk(1, 0, 1, 2, 3, 5, 7, 16'h0001),   4'b0000, 32'd0));
    tbl.push_back(mkv("lb",    mk(32, 0, 1, 6, 0, 5, 0, 16'h8000),  4'b0010, 32'hFFFF8000));
    tbl.push_back(mkv("add_r0", mk(0, 32, 1, 2, 0, 5, 7, 0),        4'b0010, 32'd7));

    foreach (tbl[k]) begin
      do_cycle(tbl[k].nm, tbl[k].i, 1'b1, 1'b0, nf);
      check_val({tbl[k].nm, " alu"}, 128'(ex_alu_control), 128'(tbl[k].exp_alu));
      check_val({tbl[k].nm, " op_b"}, 128'(ex_op_b), 128'(tbl[k].exp_b));
    end

    // Forwarding priority: MEM over WB, r0 never forwarded.
    do_cycle("fwd_mem", mk(0, 34, 4, 2, 9, 32'h44, 7, 0), 1'b1, 1'b0,
             '{1'b1, 5'd4, 32'd11, 1'b1, 5'd4, 32'd22});
    check_val("fwd_mem op_a", 128'(ex_op_a), 128'(11));
    mem_reg_write = 1'b0; #1;
    check_val("fwd_wb op_a", 128'(ex_op_a), 128'(22));
    do_cycle("fwd_r0", mk(0, 34, 0, 2, 9, 32'h33, 7, 0), 1'b1, 1'b0,
             '{1'b1, 5'd0, 32'd11, 1'b1, 5'd0, 32'd22});
    check_val("fwd_r0 op_a", 128'(ex_op_a), 128'(32'h33));

    // Load-use: one stall cycle, bubble, then the add with WB forwarding.
    lw5  = mk(35, 0, 1, 5, 0, 32'h100, 0, 16'h0008);
    add5 = mk(0, 32, 5, 2, 8, 0, 7, 0);
    do_cycle("lu_lw", lw5, 1'b1, 1'b0, nf);
    do_cycle("lu_stall", add5, 1'b1, 1'b0, nf);
    check_val("lu bubble", 128'(ex_valid), 128'(0));
    do_cycle("lu_issue", add5, 1'b1, 1'b0, '{1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h77});
    check_val("lu op_a", 128'(ex_op_a), 128'(32'h77));

    // Flush beats stall.
    do_cycle("fl_lw", lw5, 1'b1, 1'b0, nf);
    do_cycle("fl_flush", add5, 1'b1, 1'b1, nf);
    check_val("fl bubble", 128'(ex_valid), 128'(0));

    // Illegal pulses one cycle.
    do_cycle("ill", mk(0, 13, 1, 2, 3, 5, 7, 0), 1'b1, 1'b0, nf);
    check_val("ill pulse", 128'({ex_illegal, ex_reg_write, ex_mem_write}), 128'(3'b100));
    do_cycle("ill_next", mk(0, 32, 1, 2, 3, 5, 7, 0), 1'b1, 1'b0, nf);
    check_val("ill clear", 128'(ex_illegal), 128'(0));

    // Reset overrides a pending hazard.
    do_cycle("rs_lw", lw5, 1'b1, 1'b0, nf);
    reset_cycle("rst_mid", add5);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [5:0] ops [20] = '{0,0,0,2,3,4,5,8,10,12,13,14,15,32,33,35,40,41,43,1};
      logic [5:0] fns [9]  = '{32,34,36,37,38,39,42,8,13};
      ins_t ri;
      fwd_t rf;
      ri.op  = ops[$urandom_range(0, 19)];
      ri.fn  = fns[$urandom_range(0, 8)];
      ri.rs  = 5'($urandom_range(0, 7));
      ri.rt  = 5'($urandom_range(0, 7));
      ri.rd  = 5'($urandom_range(0, 7));
      ri.rsd = $urandom; ri.rtd = $urandom; ri.imm = 16'($urandom);
      rf.mrw = 1'($urandom); rf.md = 5'($urandom_range(0, 7)); rf.mres = $urandom;
      rf.wrw = 1'($urandom); rf.wd = 5'($urandom_range(0, 7)); rf.wres = $urandom;
      do_cycle("rand", ri, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), rf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
ID/EX stage controller for the pipelined MIPS core. It decodes opcode/funct into the 4-bit ALU control code and holds the ID/EX pipeline register. It selects forwarded operands and immediates for the ALU, and detects load-use hazards. On a hazard it stalls ID and inserts a bubble; the flush input squashes the instruction entering EX.

Parameters:
XLEN, 32, datapath width
RADDR, 5, register-specifier width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds an instruction
id_opcode  in  6  instr[31:26]
id_funct  in  6  instr[5:0]
id_rs, id_rt, id_rd  in  RADDR  register specifiers
id_rs_data, id_rt_data  in  XLEN  register-file read data
id_imm  in  16  instr[15:0]
flush  in  1  squash instruction entering EX (taken branch/jump)
mem_reg_write, wb_reg_write  in  1  later-stage write enables
mem_dest, wb_dest  in  RADDR  later-stage destinations
mem_result, wb_result  in  XLEN  later-stage results
stall_id  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_alu_control  out  4  ALU control code
ex_op_a, ex_op_b  out  XLEN  ALU operands, forwarded and muxed
ex_store_data  out  XLEN  forwarded rt value for stores
ex_dest  out  RADDR  write-back register
ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_bne  out  1  control bits
ex_illegal  out  1  one-cycle pulse: unsupported instruction reached EX

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: every registered field is 0, so all outputs are 0 and ex_alu_control=0000. The output stays 0 until the first decoded instruction loads.
- ALU codes: and=0000, or=0001, add=0010, sub=0110, slt=0111, nor=1100, xor=1101.
- Decode, R-type (opcode 0) by funct:
  - 32 add, 34 sub, 36 and, 37 or, 38 xor, 39 nor, 42 slt: reg_write=1, dest=rd, B=rt.
  - jr (8): add, reg_write=0.
- Decode, I-type, dest=rt, B=extended imm:
  - addi(8): add, sign-extended.
  - slti(10): slt, sign-extended.
  - andi(12): and, zero-extended.
  - ori(13): or, zero-extended.
  - xori(14): xor, zero-extended.
  - lui(15): add, A=0, B={imm,16'h0}.
- Decode, memory:
  - lb(32), lh(33), lw(35): add, sign-extended, mem_read=1, reg_write=1.
  - sb(40), sh(41), sw(43): add, sign-extended, mem_write=1, reg_write=0.
- Decode, branch: beq(4) and bne(5) use sub, B=rt, branch=1, and bne=1 for opcode 5 only.
- Decode, other: j(2) and jal(3) load a bubble with ex_valid=1 and all control bits 0. Any other opcode or funct loads a bubble with ex_illegal=1 for one cycle.
- Dest 0: a destination of 0 forces reg_write=0.
- Latency: a decoded instruction appears on the ex_* outputs one cycle after it is accepted (id_valid=1, stall_id=0, flush=0).
- Load-use hazard: hazard = ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | (ex_dest==id_rt & instruction uses rt as a source)).
  - stall_id = id_valid & hazard & ~flush, combinational.
  - While stall_id=1, the ID/EX register loads a bubble (all control 0, ex_valid=0).
  - The stall lasts exactly one cycle, because the bubble clears the hazard.
- Flush: flush=1 loads a bubble regardless of id_valid or any hazard. Flush has priority over stall.
- Forwarding: combinational on the registered rs/rt values.
  - MEM has priority over WB. A source of 0 is never forwarded, and a stage with reg_write=0 never forwards.
  - ex_op_a is the forwarded rs value, or 0 for lui.
  - ex_op_b is the forwarded rt value for R-type and branches, otherwise the extended immediate.
  - ex_store_data is always the forwarded rt value.
- Reset during operation: rst=1 overrides flush and stall and clears the pipeline register on that edge.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants
  - funct constants
  - ALU control codes
  - extension-mode enum (SIGN, ZERO, LUI)
- Sub-module alu_decode: purely combinational, opcode/funct in, control bundle out.
- Forwarding muxes and the hazard logic stay in the top module.

Test Plan:
- Reset and add: hold rst=1 for 2 cycles, then issue add rd=3, rs=1 (5), rt=2 (7). Required: all outputs 0 during reset. Next cycle: ex_alu_control=0010, op_a=5, op_b=7, ex_dest=3, reg_write=1.
- Immediate extension: issue ori imm=16'hFFFF. Required: op_b=32'h0000FFFF, code 0001. Then addi imm=16'hFFFF. Required: op_b=32'hFFFFFFFF, code 0010. Then lui imm=16'h1234. Required: op_a=0, op_b=32'h12340000.
- Forwarding priority: MEM and WB both write r4, mem_result=11 and wb_result=22, and the EX instruction sub has rs=r4. Required: op_a=11. With mem_reg_write=0: op_a=22. With dest and rs both r0: op_a=register-file value.
- Load-use stall: lw r5 in EX, then add rs=r5 in ID. Required: stall_id=1 for exactly 1 cycle, then a bubble (ex_valid=0), then the add issues with op_a=wb_result.
- Flush with stall: apply a hazard condition and flush=1 in the same cycle. Required: stall_id=0 and a bubble next cycle.
- Illegal instruction: issue R-type funct=13. Required: ex_illegal=1 for one cycle, reg_write=0, mem_write=0.
